// File: rtl/div_unit.sv
// div_unit: iterative 32-bit integer divider for the execute stage.
//
// Runs one restoring shift-subtract step per cycle: one IDLE cycle samples
// the request, 32 BUSY cycles do the steps, and a single DONE cycle presents
// the sign-corrected result with a one-cycle ready pulse. The pipeline is
// held through div_stall until that DONE cycle.
//
// Ports
//   clk        in   1   pipeline clock (rising edge)
//   rst        in   1   asynchronous reset, active low
//   a          in  32   dividend
//   b          in  32   divisor
//   signed_div in   1   1 = DIV (two's complement), 0 = DIVU
//   start      in   1   request a division (only honoured in IDLE)
//   annul      in   1   abort the operation in flight
//   result     out 64   {remainder, quotient}, held until the next DONE
//   ready      out  1   one-cycle pulse, result valid in that cycle
//   div_stall  out  1   stall request to the hazard unit
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        signed_div,
  input  logic        start,
  input  logic        annul,
  output logic [63:0] result,
  output logic        ready,
  output logic        div_stall
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} divState_t;

  // Per-operation context captured when the request is accepted.
  typedef struct packed {
    logic        quotSign;
    logic        remSign;
    logic        zeroDiv;
    logic [31:0] divisor;
  } opCtx_t;

  divState_t   state, stateNext;
  logic [5:0]  iterCnt;
  logic [64:0] work;       // {partial remainder[64:32], dividend/quotient[31:0]}
  opCtx_t      ctx;

  logic        accept;
  logic        lastStep;
  logic [31:0] absA, absB;
  logic [33:0] trialSub;
  logic [64:0] workStep;
  logic [31:0] quotRaw, remRaw, quotFix, remFix;

  assign accept   = (state == IDLE) && start && !annul;
  assign lastStep = (iterCnt == 6'd31);

  assign absA = (signed_div && a[31]) ? -a : a;
  assign absB = (signed_div && b[31]) ? -b : b;

  // One restoring step. The shifted partial remainder can reach 33 bits, so
  // the trial subtraction is done at 34 bits and bit 33 is the borrow.
  assign trialSub = {1'b0, work[63:31]} - {2'b00, ctx.divisor};
  assign workStep = trialSub[33] ? {work[63:0], 1'b0}
                                 : {trialSub[32:0], work[30:0], 1'b1};

  // The remainder is always below the divisor, so it fits in 32 bits.
  assign quotRaw = workStep[31:0];
  assign remRaw  = workStep[63:32];

  // With b == 0 every trial succeeds, leaving |a| as the remainder; undoing
  // the dividend sign restores the raw a. The quotient is forced to all ones
  // so the sign fix-up cannot turn it into 1.
  assign quotFix = ctx.zeroDiv  ? 32'hFFFF_FFFF
                 : ctx.quotSign ? -quotRaw : quotRaw;
  assign remFix  = ctx.remSign  ? -remRaw : remRaw;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (accept) stateNext = BUSY;
      BUSY: begin
        if (annul)         stateNext = IDLE;
        else if (lastStep) stateNext = DONE;
      end
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      iterCnt <= '0;
      work    <= '0;
      ctx     <= '0;
      result  <= '0;
    end else if (accept) begin
      iterCnt      <= '0;
      work         <= {33'd0, absA};
      ctx.quotSign <= signed_div && (a[31] ^ b[31]);
      ctx.remSign  <= signed_div && a[31];
      ctx.zeroDiv  <= (b == 32'd0);
      ctx.divisor  <= absB;
    end else if ((state == BUSY) && !annul) begin
      iterCnt <= iterCnt + 6'd1;
      work    <= workStep;
      if (lastStep) result <= {remFix, quotFix};
    end
  end

  assign ready     = (state == DONE);
  assign div_stall = accept || (state == BUSY);

endmodule

// File: tb/tb_div_unit.sv
// Randomised, self-checking bench for div_unit. A cycle-level reference
// (remaining-cycles counter plus plain integer division) is compared with
// the DUT on every falling edge; directed operations pin known results.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] a, b;
  logic        signed_div, start, annul;
  logic [63:0] result;
  logic        ready, div_stall;

  int tests = 0;
  int fails = 0;

  div_unit dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .signed_div(signed_div),
    .start(start), .annul(annul), .result(result), .ready(ready),
    .div_stall(div_stall)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] divModel(input logic [31:0] x, input logic [31:0] y,
                                           input logic sd);
    longint sx, sy, q, r;
    if (y == 32'd0) return {x, 32'hFFFF_FFFF};
    if (!sd) return {x % y, x / y};
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    q  = sx / sy;
    r  = sx % sy;
    return {r[31:0], q[31:0]};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: mRemain counts cycles left in the operation (33 after the
  // accepting edge, 1 means the result cycle).
  int          mRemain = 0;
  logic [63:0] mExp    = '0;
  logic [63:0] mResult = '0;
  int          mPulses = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mRemain = 0;
      mResult = '0;
    end else if (mRemain == 0) begin
      if (start && !annul) begin
        mRemain = 33;
        mExp    = divModel(a, b, signed_div);
      end
    end else if (annul) begin
      mRemain = 0;
    end else begin
      mRemain--;
      if (mRemain == 1) begin
        mResult = mExp;
        mPulses++;
      end
    end
  end

  always @(negedge clk) begin
    chk("ready",     {63'd0, ready},     {63'd0, mRemain == 1});
    chk("div_stall", {63'd0, div_stall},
        {63'd0, (mRemain == 0 && start && !annul) || mRemain >= 2});
    chk("result",    result, mResult);
  end

  // Issue one operation, scramble operands afterwards, and expect the
  // result pulse on the 33rd falling edge after the sampling edge.
  task automatic runOp(input logic [31:0] ia, input logic [31:0] ib, input logic sd,
                       input logic [63:0] lit, input string name);
    int n;
    @(posedge clk); #1;
    a = ia; b = ib; signed_div = sd; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = $urandom; b = $urandom; signed_div = 1'($urandom_range(0, 1));
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!ready && n < 40);
    chk({name, "_latency"}, 64'(n), 64'd33);
    chk({name, "_result"}, result, lit);
  endtask

  logic [31:0] ra, rb;
  logic        rsd;
  int          readyAt[$];
  int          sawReady;

  initial begin
    rst = 1'b0; a = '0; b = '0; signed_div = 1'b0; start = 1'b0; annul = 1'b0;
    #2;
    chk("reset_result", result, 64'd0);
    chk("reset_ready", {63'd0, ready}, 64'd0);
    chk("reset_stall", {63'd0, div_stall}, 64'd0);
    start = 1'b1; #1;
    chk("reset_stall_start", {63'd0, div_stall}, 64'd1);
    start = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;

    runOp(32'd100, 32'd7, 1'b0, {32'd2, 32'd14}, "divu_100_7");
    runOp(32'hFFFF_FFF9, 32'd2, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, "div_m7_2");
    runOp(32'd7, 32'hFFFF_FFFE, 1'b1, {32'd1, 32'hFFFF_FFFD}, "div_7_m2");
    runOp(32'h1234_5678, 32'd0, 1'b1, {32'h1234_5678, 32'hFFFF_FFFF}, "div_by0");
    runOp(32'h1234_5678, 32'd0, 1'b0, {32'h1234_5678, 32'hFFFF_FFFF}, "divu_by0");
    runOp(32'h8000_0005, 32'd0, 1'b1, {32'h8000_0005, 32'hFFFF_FFFF}, "div_neg_by0");
    runOp(32'hFFFF_FFFF, 32'd1, 1'b0, {32'd0, 32'hFFFF_FFFF}, "divu_max_1");
    runOp(32'd5, 32'hFFFF_FFFF, 1'b0, {32'd5, 32'd0}, "divu_5_max");
    runOp(32'hFFFF_FF9C, 32'hFFFF_FFF9, 1'b1, {32'hFFFF_FFFE, 32'd14}, "div_m100_m7");

    // Annul in BUSY cycle 10 of 50/5.
    @(posedge clk); #1;
    a = 32'd50; b = 32'd5; signed_div = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 annul = 1'b1;
    @(negedge clk);
    chk("annul_stall_busy", {63'd0, div_stall}, 64'd1);
    @(posedge clk); #1;
    annul = 1'b0;
    chk("annul_stall_idle", {63'd0, div_stall}, 64'd0);
    sawReady = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready) sawReady++;
    end
    chk("annul_no_ready", 64'(sawReady), 64'd0);
    chk("annul_result_kept", result, {32'hFFFF_FFFE, 32'd14});
    runOp(32'd60, 32'd6, 1'b0, {32'd0, 32'd10}, "divu_60_6");

    // Start and annul together in IDLE: nothing starts.
    @(posedge clk); #1;
    start = 1'b1; annul = 1'b1;
    #1 chk("start_annul_stall", {63'd0, div_stall}, 64'd0);
    @(posedge clk); #1;
    start = 1'b0; annul = 1'b0;
    chk("start_annul_idle", {63'd0, div_stall}, 64'd0);

    // Reset in BUSY cycle 20.
    @(posedge clk); #1;
    a = 32'd1000; b = 32'd3; signed_div = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    chk("rst_mid_result", result, 64'd0);
    chk("rst_mid_ready", {63'd0, ready}, 64'd0);
    chk("rst_mid_stall", {63'd0, div_stall}, 64'd0);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    runOp(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'd0, 32'h8000_0000}, "div_ovf");

    // Start held high across two operations.
    @(posedge clk); #1;
    a = 32'd1000; b = 32'd7; signed_div = 1'b0; start = 1'b1;
    for (int i = 1; i <= 75; i++) begin
      @(negedge clk);
      if (ready) readyAt.push_back(i);
    end
    @(posedge clk); #1;
    start = 1'b0;
    chk("held_pulses", 64'(readyAt.size()), 64'd2);
    if (readyAt.size() >= 2) begin
      chk("held_first", 64'(readyAt[0]), 64'd34);
      chk("held_spacing", 64'(readyAt[1] - readyAt[0]), 64'd34);
    end
    repeat (40) @(posedge clk);

    // Randomised directed operations with latency check.
    for (int i = 0; i < 20; i++) begin
      ra  = $urandom;
      rb  = (i % 4 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
      rsd = 1'($urandom_range(0, 1));
      if (i % 7 == 0) rb = ra;
      runOp(ra, rb, rsd, divModel(ra, rb, rsd), "rand_op");
    end

    // Free-running random traffic checked only by the reference.
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      start      = ($urandom_range(0, 3) == 0);
      annul      = ($urandom_range(0, 59) == 0);
      signed_div = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0:       a = 32'h8000_0000;
        1:       a = 32'($urandom_range(0, 100));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFF_FFFF;
        2:       b = 32'($urandom_range(1, 16));
        default: b = $urandom;
      endcase
    end
    @(posedge clk); #1;
    start = 1'b0; annul = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
